// File: rtl/mandelbrot_gen.sv
// Mandelbrot frame generator: one Q4.12 iteration engine walks the frame in raster order
// and writes one 12-bit RGB word per pixel into the line-bank framebuffer.
module mandelbrot_gen #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int BANK_LINES = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 12,
  parameter int FIX_WIDTH  = 16,
  parameter int FRAC_BITS  = 12,
  parameter int MAX_ITER   = 63,
  parameter int ITER_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_start,
  input  logic [FIX_WIDTH-1:0]  i_x0,
  input  logic [FIX_WIDTH-1:0]  i_y0,
  input  logic [FIX_WIDTH-1:0]  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [3:0]            o_bank,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_write,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int DEPTH = H_RES * BANK_LINES;
  localparam int XW    = $clog2(H_RES);
  localparam int YW    = $clog2(V_RES);
  localparam int PW    = 2 * FIX_WIDTH;
  localparam logic signed [PW-1:0] C_FOUR = PW'(4 * (2 ** FRAC_BITS));

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic signed [FIX_WIDTH-1:0] r_zr;
  logic signed [FIX_WIDTH-1:0] r_zi;
  logic signed [FIX_WIDTH-1:0] r_cr;
  logic signed [FIX_WIDTH-1:0] r_ci;
  logic signed [FIX_WIDTH-1:0] r_x0;
  logic signed [FIX_WIDTH-1:0] r_step;

  logic [ITER_WIDTH-1:0] r_iter;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_bank;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_busy;
  logic                  r_done;

  logic signed [PW-1:0]        w_zr_x;
  logic signed [PW-1:0]        w_zi_x;
  logic signed [PW-1:0]        w_cr_x;
  logic signed [PW-1:0]        w_ci_x;
  logic signed [PW-1:0]        w_prr;
  logic signed [PW-1:0]        w_pii;
  logic signed [PW-1:0]        w_pri;
  logic signed [PW-1:0]        w_zr2;
  logic signed [PW-1:0]        w_zi2;
  logic signed [PW-1:0]        w_zri;
  logic signed [PW-1:0]        w_mag;
  logic signed [FIX_WIDTH-1:0] w_zr_nx;
  logic signed [FIX_WIDTH-1:0] w_zi_nx;
  logic                        w_escape;
  logic                        w_exit;
  logic                        w_line_end;
  logic                        w_last_px;
  logic                        w_bank_end;

  // Escape-count to colour; points that never escape are painted black.
  function automatic logic [DATA_WIDTH-1:0] colour(input logic [ITER_WIDTH-1:0] cnt);
    if (cnt == ITER_WIDTH'(MAX_ITER)) begin
      return '0;
    end
    return {cnt[3:0], cnt[5:2], 4'hF - cnt[3:0]};
  endfunction

  assign w_zr_x = {{FIX_WIDTH{r_zr[FIX_WIDTH-1]}}, r_zr};
  assign w_zi_x = {{FIX_WIDTH{r_zi[FIX_WIDTH-1]}}, r_zi};
  assign w_cr_x = {{FIX_WIDTH{r_cr[FIX_WIDTH-1]}}, r_cr};
  assign w_ci_x = {{FIX_WIDTH{r_ci[FIX_WIDTH-1]}}, r_ci};

  // Full-width products, rescaled back to Q.12 with arithmetic shifts.
  assign w_prr = w_zr_x * w_zr_x;
  assign w_pii = w_zi_x * w_zi_x;
  assign w_pri = w_zr_x * w_zi_x;
  assign w_zr2 = w_prr >>> FRAC_BITS;
  assign w_zi2 = w_pii >>> FRAC_BITS;
  assign w_zri = w_pri >>> FRAC_BITS;
  assign w_mag = w_zr2 + w_zi2;

  assign w_zr_nx = FIX_WIDTH'(w_zr2 - w_zi2 + w_cr_x);
  assign w_zi_nx = FIX_WIDTH'((w_zri <<< 1) + w_ci_x);

  assign w_escape   = (w_mag > C_FOUR);
  assign w_exit     = w_escape || (r_iter == ITER_WIDTH'(MAX_ITER));
  assign w_line_end = (r_x == XW'(H_RES - 1));
  assign w_last_px  = w_line_end && (r_y == YW'(V_RES - 1));
  assign w_bank_end = (r_addr == ADDR_WIDTH'(DEPTH - 1));

  always_comb begin
    w_state_nx = r_state;
    if (i_enable) begin
      case (r_state)
        S_IDLE:  if (i_start) w_state_nx = S_INIT;
        S_INIT:  w_state_nx = S_ITER;
        S_ITER:  if (w_exit) w_state_nx = S_WRITE;
        S_WRITE: w_state_nx = w_last_px ? S_DONE : S_INIT;
        S_DONE:  w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Control, pixel counters and registered outputs.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_iter <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
      r_bank <= '0;
      r_data <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_enable) begin
      r_busy <= (w_state_nx == S_INIT) || (w_state_nx == S_ITER) || (w_state_nx == S_WRITE);
      r_done <= (w_state_nx == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
            r_bank <= '0;
          end
        end
        S_INIT: r_iter <= '0;
        S_ITER: begin
          if (w_exit) begin
            r_data <= colour(r_iter);
          end else begin
            r_iter <= r_iter + ITER_WIDTH'(1);
          end
        end
        S_WRITE: begin
          // The final pixel keeps its address so the bank select never leaves 0..14.
          if (!w_last_px) begin
            if (w_line_end) begin
              r_x <= '0;
              r_y <= r_y + YW'(1);
            end else begin
              r_x <= r_x + XW'(1);
            end
            if (w_bank_end) begin
              r_addr <= '0;
              r_bank <= r_bank + 4'd1;
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Iteration datapath: values are only consumed after INIT/IDLE load them.
  always_ff @(posedge clk) begin
    if (i_enable) begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x0   <= i_x0;
            r_step <= i_step;
            r_cr   <= i_x0;
            r_ci   <= i_y0;
          end
        end
        S_INIT: begin
          r_zr <= '0;
          r_zi <= '0;
        end
        S_ITER: begin
          if (!w_exit) begin
            r_zr <= w_zr_nx;
            r_zi <= w_zi_nx;
          end
        end
        S_WRITE: begin
          if (!w_last_px) begin
            if (w_line_end) begin
              r_cr <= r_x0;
              r_ci <= r_ci - r_step;
            end else begin
              r_cr <= r_cr + r_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_write = (r_state == S_WRITE) && i_enable;
  assign o_addr  = r_addr;
  assign o_bank  = r_bank;
  assign o_data  = r_data;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_mandelbrot_gen.sv
// Bench for mandelbrot_gen on a reduced 20x12 raster (4-line banks) so whole frames fit the cycle budget.
module tb_mandelbrot_gen;

  localparam int H     = 20;
  localparam int V     = 12;
  localparam int BL    = 4;
  localparam int DEPTH = H * BL;
  localparam int MAXI  = 63;
  localparam int FRAC  = 12;
  localparam int BOUND = 50000;

  logic        clk      = 1'b0;
  logic        i_rst_n  = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_start  = 1'b0;
  logic [15:0] i_x0     = '0;
  logic [15:0] i_y0     = '0;
  logic [15:0] i_step   = '0;
  logic [12:0] o_addr;
  logic [3:0]  o_bank;
  logic [11:0] o_data;
  logic        o_write;
  logic        o_busy;
  logic        o_done;

  int errors = 0;
  int checks = 0;
  logic [28:0] wq[$];
  logic [28:0] exp_q[$];
  int last_wr_cyc, done_cyc, done_hi, done_rise, bad_strobe, busy_in_done;

  always #5 clk = ~clk;

  mandelbrot_gen #(.H_RES(H), .V_RES(V), .BANK_LINES(BL)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_start(i_start),
    .i_x0(i_x0), .i_y0(i_y0), .i_step(i_step),
    .o_addr(o_addr), .o_bank(o_bank), .o_data(o_data),
    .o_write(o_write), .o_busy(o_busy), .o_done(o_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint wrap16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return t;
  endfunction

  // Plain escape-time iteration on integers holding Q4.12 values.
  function automatic int mcount(input longint cr, input longint ci);
    longint zr, zi, zr2, zi2, zri;
    zr = 0;
    zi = 0;
    for (int it = 0; it <= MAXI; it++) begin
      zr2 = (zr * zr) >>> FRAC;
      zi2 = (zi * zi) >>> FRAC;
      zri = (zr * zi) >>> FRAC;
      if ((zr2 + zi2 > 16384) || (it == MAXI)) return it;
      zr = wrap16(zr2 - zi2 + cr);
      zi = wrap16(zri * 2 + ci);
    end
    return MAXI;
  endfunction

  function automatic int colour_of(input int c);
    if (c == MAXI) return 0;
    return ((c & 15) << 8) | (((c >> 2) & 15) << 4) | (15 - (c & 15));
  endfunction

  task automatic build_model(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] st);
    longint x0l, y0l, stl, cr, ci;
    int cnt;
    x0l = longint'($signed(x0));
    y0l = longint'($signed(y0));
    stl = longint'($signed(st));
    exp_q.delete();
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        cr  = wrap16(x0l + longint'(x) * stl);
        ci  = wrap16(y0l - longint'(y) * stl);
        cnt = mcount(cr, ci);
        exp_q.push_back({4'(y / BL), 13'((y % BL) * H + x), 12'(colour_of(cnt))});
      end
    end
  endtask

  // Starts a frame and records every strobe until the done pulse has come and gone.
  task automatic run_frame(input bit stall, input bit poke);
    bit prev_done;
    wq.delete();
    last_wr_cyc = -1; done_cyc = -1; done_hi = 0; done_rise = 0;
    bad_strobe = 0; busy_in_done = 0; prev_done = 1'b0;
    i_enable = 1'b1;
    i_start  = 1'b1;
    tick();
    i_start = 1'b0;
    for (int cyc = 0; cyc < BOUND; cyc++) begin
      i_enable = stall ? (cyc % 3 == 0) : 1'b1;
      if (poke) begin
        i_start = (cyc >= 100 && cyc <= 110);
        if (cyc == 100) i_x0 = 16'h0000;
      end
      @(negedge clk);
      if (o_write) begin
        wq.push_back({o_bank, o_addr, o_data});
        last_wr_cyc = cyc;
        if (!i_enable) bad_strobe++;
      end
      if (o_done) begin
        done_hi++;
        if (!prev_done) begin
          done_rise++;
          done_cyc = cyc;
        end
        if (o_busy) busy_in_done++;
      end
      prev_done = o_done;
      if (done_rise > 0 && !o_done) break;
      tick();
    end
    i_start  = 1'b0;
    i_enable = 1'b1;
    tick();
  endtask

  task automatic compare_frame(input string tag, input bit single_done);
    check({tag, "_nwr"}, wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wq[i], exp_q[i]);
    check({tag, "_done_pulses"}, done_rise, 1);
    check({tag, "_done_cyc"}, done_cyc, last_wr_cyc + 1);
    if (single_done) check({tag, "_done_len"}, done_hi, 1);
    check({tag, "_busy_in_done"}, busy_in_done, 0);
    check({tag, "_strobe_en_low"}, bad_strobe, 0);
  endtask

  task automatic first_write(output int n);
    n = 1;
    while (!o_write && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [15:0] rx0, ry0, rst;

    i_rst_n = 1'b0;
    tick();
    tick();
    check("rst_addr", o_addr, 0);
    check("rst_bank", o_bank, 0);
    check("rst_data", o_data, 0);
    check("rst_done", o_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_write", o_write, 0);
    i_rst_n = 1'b1;
    tick();

    i_x0 = 16'h2800; i_y0 = 16'h0000; i_step = 16'h0000;
    i_enable = 1'b1;
    i_start  = 1'b1;
    tick();
    i_start = 1'b0;
    check("init_busy", o_busy, 1);
    first_write(n);
    check("esc_latency", n, 4);
    check("esc_data", o_data, 12'h10E);
    check("esc_addr", o_addr, 0);
    check("esc_bank", o_bank, 0);
    tick();
    tick();
    check("esc_addr_next", o_addr, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_addr", o_addr, 0);
    check("midrst_bank", o_bank, 0);
    check("midrst_data", o_data, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_write", o_write, 0);
    tick();
    i_rst_n = 1'b1;
    tick();

    i_x0 = 16'h0000; i_y0 = 16'h0000; i_step = 16'h0000;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    first_write(n);
    check("inside_latency", n, 66);
    check("inside_data", o_data, 12'h000);
    check("inside_addr", o_addr, 0);
    check("inside_bank", o_bank, 0);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();

    i_x0 = 16'h2800; i_y0 = 16'h0000; i_step = 16'h0000;
    build_model(16'h2800, 16'h0000, 16'h0000);
    run_frame(1'b0, 1'b1);
    compare_frame("addrseq", 1'b1);
    if (wq.size() > DEPTH) begin
      check("bank1_first", wq[DEPTH], {4'd1, 13'd0, 12'h10E});
    end else begin
      check("bank1_first_present", wq.size(), DEPTH + 1);
    end
    if (wq.size() > 0) begin
      check("last_write", wq[wq.size() - 1], {4'(V / BL - 1), 13'(DEPTH - 1), 12'h10E});
    end else begin
      check("last_write_present", 0, 1);
    end

    rx0 = 16'(-8192 + int'($urandom_range(0, 6144)));
    ry0 = 16'($urandom_range(0, 4096));
    rst = 16'($urandom_range(40, 200));
    i_x0 = rx0; i_y0 = ry0; i_step = rst;
    build_model(rx0, ry0, rst);
    run_frame(1'b0, 1'b0);
    compare_frame("rnd", 1'b1);
    run_frame(1'b1, 1'b0);
    compare_frame("stall", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
